// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer
// Polls one power-monitor device through an i2c_master ena/busy handshake.
// Each sweep reads NUM_REGS 16-bit registers (pointer write, repeated start,
// two read bytes) and reports every register on a one-cycle result strobe.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   enable          periodic polling on; 0 stops the sweep after the current register
//   trig            one-cycle request for an immediate sweep
//   i2c_ena/addr/rw/data_wr   command handshake towards i2c_master
//   i2c_busy/data_rd/ack_error status and read data from i2c_master
//   res_valid       one-cycle strobe qualifying res_idx/res_data/res_err
//   sweep_done      one-cycle strobe after the last register of a sweep
//   overrun         one-cycle strobe when a request is dropped
module i2c_poll_sequencer #(
    parameter logic [6:0]  DEV_ADDR  = 7'h40,
    parameter logic [7:0]  REG_BASE  = 8'h01,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned IDXW      = 2,
    parameter int unsigned POLL_DIV  = 1_000_000,
    parameter int unsigned TIMEOUT   = 65_535,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            trig,
    output logic            i2c_ena,
    output logic [6:0]      i2c_addr,
    output logic            i2c_rw,
    output logic [7:0]      i2c_data_wr,
    input  logic            i2c_busy,
    input  logic [7:0]      i2c_data_rd,
    input  logic            i2c_ack_error,
    output logic            res_valid,
    output logic [IDXW-1:0] res_idx,
    output logic [15:0]     res_data,
    output logic            res_err,
    output logic            sweep_done,
    output logic            overrun
);

    localparam int unsigned CW  = 32;
    localparam int unsigned RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_RD,
        S_DONE_WAIT,
        S_ABORT,
        S_NEXT
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [RTW-1:0]  retry_q, retry_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   poll_q, poll_d;
    logic            pending_q, pending_d;
    logic            busy_q;
    logic [7:0]      msb_q, msb_d;
    logic [7:0]      lsb_q, lsb_d;
    logic            ack_q, ack_d;

    logic            ena_d, rw_d;
    logic [7:0]      data_wr_d;
    logic            res_valid_d, res_err_d, sweep_done_d, overrun_d;
    logic [IDXW-1:0] res_idx_d;
    logic [15:0]     res_data_d;

    logic            tick_c, req_c, busy_rise_c, busy_fall_c, edge_c, timeout_c, launch_c;

    assign i2c_addr = DEV_ADDR;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        bcnt_d       = bcnt_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        msb_d        = msb_q;
        lsb_d        = lsb_q;
        ack_d        = ack_q;
        ena_d        = i2c_ena;
        rw_d         = i2c_rw;
        data_wr_d    = i2c_data_wr;
        res_valid_d  = 1'b0;
        res_idx_d    = res_idx;
        res_data_d   = res_data;
        res_err_d    = res_err;
        sweep_done_d = 1'b0;
        overrun_d    = 1'b0;
        launch_c     = 1'b0;

        // Sweep tick timer, held at zero while polling is off
        tick_c = enable && (poll_q == CW'(POLL_DIV - 1));
        poll_d = (!enable || tick_c) ? '0 : poll_q + CW'(1);
        req_c  = tick_c | trig;

        busy_rise_c = i2c_busy & ~busy_q;
        busy_fall_c = ~i2c_busy & busy_q;
        edge_c      = busy_rise_c | busy_fall_c;
        timeout_c   = !edge_c && (timer_q == CW'(TIMEOUT - 1));

        // One request may wait while a sweep runs; a second one is dropped
        if (state_q != S_IDLE && req_c) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (state_q == S_PTR || state_q == S_RD || state_q == S_DONE_WAIT) begin
            timer_d = edge_c ? '0 : timer_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (req_c || pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    retry_d   = '0;
                    launch_c  = 1'b1;
                end
            end
            S_PTR: begin
                if (timeout_c) begin
                    ena_d   = 1'b0;
                    state_d = S_ABORT;
                end else if (busy_rise_c) begin
                    // Pointer write accepted: queue the read for the repeated start
                    bcnt_d  = 2'd1;
                    rw_d    = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (timeout_c) begin
                    ena_d   = 1'b0;
                    state_d = S_ABORT;
                end else if (busy_rise_c) begin
                    if (bcnt_q == 2'd1) begin
                        bcnt_d = 2'd2;
                    end else if (bcnt_q == 2'd2) begin
                        // Second read accepted: first byte is on data_rd, end after this one
                        msb_d   = i2c_data_rd;
                        bcnt_d  = 2'd3;
                        ena_d   = 1'b0;
                        state_d = S_DONE_WAIT;
                    end
                end
            end
            S_DONE_WAIT: begin
                if (timeout_c) begin
                    ena_d   = 1'b0;
                    state_d = S_ABORT;
                end else if (busy_fall_c) begin
                    lsb_d   = i2c_data_rd;
                    ack_d   = i2c_ack_error;
                    state_d = S_NEXT;
                end
            end
            S_ABORT: begin
                // Stalled transfer is treated like a NACK once the master is idle
                if (!i2c_busy) begin
                    ack_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ack_q && (retry_q < RTW'(MAX_RETRY))) begin
                    retry_d  = retry_q + RTW'(1);
                    launch_c = 1'b1;
                end else begin
                    res_valid_d = 1'b1;
                    res_idx_d   = idx_q;
                    res_err_d   = ack_q;
                    res_data_d  = ack_q ? 16'h0000 : {msb_q, lsb_q};
                    retry_d     = '0;
                    if (idx_q == IDXW'(NUM_REGS - 1)) begin
                        sweep_done_d = 1'b1;
                        idx_d        = '0;
                        state_d      = S_IDLE;
                    end else if (!enable) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d    = idx_q + IDXW'(1);
                        launch_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start a register attempt: pointer write for idx_d
        if (launch_c) begin
            state_d   = S_PTR;
            ena_d     = 1'b1;
            rw_d      = 1'b0;
            data_wr_d = REG_BASE + 8'(idx_d);
            bcnt_d    = 2'd0;
            timer_d   = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            bcnt_q      <= '0;
            timer_q     <= '0;
            poll_q      <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            msb_q       <= '0;
            lsb_q       <= '0;
            ack_q       <= 1'b0;
            i2c_ena     <= 1'b0;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= '0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_data    <= '0;
            res_err     <= 1'b0;
            sweep_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            bcnt_q      <= bcnt_d;
            timer_q     <= timer_d;
            poll_q      <= poll_d;
            pending_q   <= pending_d;
            busy_q      <= i2c_busy;
            msb_q       <= msb_d;
            lsb_q       <= lsb_d;
            ack_q       <= ack_d;
            i2c_ena     <= ena_d;
            i2c_rw      <= rw_d;
            i2c_data_wr <= data_wr_d;
            res_valid   <= res_valid_d;
            res_idx     <= res_idx_d;
            res_data    <= res_data_d;
            res_err     <= res_err_d;
            sweep_done  <= sweep_done_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: behavioural i2c_master/slave model, result
// monitor and directed sweeps (normal, single NACK, permanent NACK, dead
// master, overrun, enable drop, mid-transfer reset).
`timescale 1ns/1ps
module tb_i2c_poll_sequencer;

    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned IDXW      = 2;
    localparam int unsigned POLL_DIV  = 200;
    localparam int unsigned TIMEOUT   = 10;
    localparam int unsigned MAX_RETRY = 2;
    localparam int          BYTE_LEN  = 3;
    localparam int          GAP_LEN   = 1;

    logic            clk = 1'b0;
    logic            rst, enable, trig;
    logic            i2c_ena, i2c_rw;
    logic [6:0]      i2c_addr;
    logic [7:0]      i2c_data_wr;
    logic            busy = 1'b0;
    logic            ack_err = 1'b0;
    logic [7:0]      data_rd = 8'h00;
    logic            res_valid, res_err, sweep_done, overrun;
    logic [IDXW-1:0] res_idx;
    logic [15:0]     res_data;

    int checks = 0;
    int errors = 0;

    i2c_poll_sequencer #(
        .DEV_ADDR (7'h40),
        .REG_BASE (8'h01),
        .NUM_REGS (NUM_REGS),
        .IDXW     (IDXW),
        .POLL_DIV (POLL_DIV),
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .trig         (trig),
        .i2c_ena      (i2c_ena),
        .i2c_addr     (i2c_addr),
        .i2c_rw       (i2c_rw),
        .i2c_data_wr  (i2c_data_wr),
        .i2c_busy     (busy),
        .i2c_data_rd  (data_rd),
        .i2c_ack_error(ack_err),
        .res_valid    (res_valid),
        .res_idx      (res_idx),
        .res_data     (res_data),
        .res_err      (res_err),
        .sweep_done   (sweep_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Master/slave model: 0 ack all, 1 NACK idx 2 once, 2 NACK all, 3 dead master
    int mode = 0;
    int nack2_at = 0;
    int ptr_att [0:15];
    int m_phase = 0, m_cnt = 0, m_byte = 0, m_k = 0, mk = 0;
    logic m_nack = 1'b0;

    initial for (int i = 0; i < 16; i++) ptr_att[i] = 0;

    always @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            ack_err <= 1'b0;
            data_rd <= 8'h00;
            m_phase <= 0;
            m_cnt   <= 0;
            m_byte  <= 0;
        end else begin
            case (m_phase)
                0: if (i2c_ena && mode != 3) begin
                    mk = int'(i2c_data_wr) - 1;
                    busy    <= 1'b1;
                    ack_err <= 1'b0;
                    m_byte  <= 0;
                    m_cnt   <= 0;
                    m_phase <= 1;
                    m_k     <= mk;
                    if (mk >= 0 && mk < 16) begin
                        ptr_att[mk] <= ptr_att[mk] + 1;
                        m_nack <= (mode == 2) || (mode == 1 && mk == 2 && ptr_att[mk] + 1 == nack2_at);
                    end else begin
                        m_nack <= 1'b1;
                    end
                end
                1: if (m_cnt == BYTE_LEN - 1) begin
                    busy    <= 1'b0;
                    m_cnt   <= 0;
                    m_phase <= 2;
                    if (m_byte == 1) data_rd <= 8'h10;
                    else if (m_byte == 2) data_rd <= 8'(m_k);
                    if (m_nack) ack_err <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (m_cnt == GAP_LEN - 1) begin
                    m_cnt <= 0;
                    if (i2c_ena) begin
                        busy    <= 1'b1;
                        m_byte  <= m_byte + 1;
                        m_phase <= 1;
                    end else begin
                        m_phase <= 0;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    // Output monitor
    int cyc = 0, res_cnt = 0, sweeps = 0, overruns = 0;
    int ena_rises = 0, ena_hi = 0, done_cyc = 0, start_lat = 999;
    logic ena_prev = 1'b0;
    logic arm = 1'b0;
    logic [IDXW-1:0] log_idx  [0:127];
    logic [15:0]     log_data [0:127];
    logic            log_err  [0:127];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (res_valid) begin
            if (res_cnt < 128) begin
                log_idx[res_cnt]  = res_idx;
                log_data[res_cnt] = res_data;
                log_err[res_cnt]  = res_err;
            end
            res_cnt = res_cnt + 1;
        end
        if (sweep_done) begin
            sweeps   = sweeps + 1;
            done_cyc = cyc;
            arm      = 1'b1;
        end
        if (overrun) overruns = overruns + 1;
        if (i2c_ena && !ena_prev) begin
            ena_rises = ena_rises + 1;
            if (arm) begin
                start_lat = cyc - done_cyc;
                arm = 1'b0;
            end
        end
        if (i2c_ena) ena_hi = ena_hi + 1;
        ena_prev = i2c_ena;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_sweeps(input string tn, input int target, input int budget);
        for (int i = 0; i < budget && sweeps < target; i++) @(posedge clk);
        check({tn, "_sweep_seen"}, 32'(sweeps >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic expect_results(input string tn, input int base, input logic err_exp);
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (base + k < 128) begin
                check($sformatf("%s_idx%0d", tn, k), 32'(log_idx[base+k]), 32'(k));
                check($sformatf("%s_data%0d", tn, k), 32'(log_data[base+k]),
                      err_exp ? 32'h0 : 32'h1000 + 32'(k));
                check($sformatf("%s_err%0d", tn, k), 32'(log_err[base+k]), 32'(err_exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b_res, b_sw, b_ov, b_er, b_eh;
        int b_att [0:3];

        rst = 1'b1; enable = 1'b0; trig = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ena", 32'(i2c_ena), 32'd0);
        check("rst_addr", 32'(i2c_addr), 32'h40);
        check("rst_rw", 32'(i2c_rw), 32'd0);
        check("rst_data_wr", 32'(i2c_data_wr), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_idx", 32'(res_idx), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: all ACK, one triggered sweep
        mode = 0; b_res = res_cnt; b_sw = sweeps; b_ov = overruns;
        enable = 1'b1;
        pulse_trig();
        wait_sweeps("t1", b_sw + 1, 195);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_nres", 32'(res_cnt - b_res), 32'd4);
        check("t1_nsweep", 32'(sweeps - b_sw), 32'd1);
        check("t1_overrun", 32'(overruns - b_ov), 32'd0);
        expect_results("t1", b_res, 1'b0);

        // 2: NACK on the first attempt of idx 2 only
        mode = 1; nack2_at = ptr_att[2] + 1;
        for (int k = 0; k < 4; k++) b_att[k] = ptr_att[k];
        b_res = res_cnt; b_sw = sweeps;
        enable = 1'b1;
        pulse_trig();
        wait_sweeps("t2", b_sw + 1, 195);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_nres", 32'(res_cnt - b_res), 32'd4);
        check("t2_att1", 32'(ptr_att[1] - b_att[1]), 32'd1);
        check("t2_att2", 32'(ptr_att[2] - b_att[2]), 32'd2);
        expect_results("t2", b_res, 1'b0);

        // 3: device always NACKs
        mode = 2;
        for (int k = 0; k < 4; k++) b_att[k] = ptr_att[k];
        b_res = res_cnt; b_sw = sweeps;
        enable = 1'b1;
        pulse_trig();
        wait_sweeps("t3", b_sw + 1, 195);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_nres", 32'(res_cnt - b_res), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_att%0d", k), 32'(ptr_att[k] - b_att[k]), 32'(MAX_RETRY + 1));
        expect_results("t3", b_res, 1'b1);

        // 4: dead master, busy never rises
        mode = 3;
        b_res = res_cnt; b_sw = sweeps; b_er = ena_rises; b_eh = ena_hi;
        enable = 1'b1;
        pulse_trig();
        wait_sweeps("t4", b_sw + 1, 195);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_attempts", 32'(ena_rises - b_er), 32'(NUM_REGS * (MAX_RETRY + 1)));
        check("t4_ena_cycles", 32'(ena_hi - b_eh), 32'(NUM_REGS * (MAX_RETRY + 1) * TIMEOUT));
        check("t4_ena_low", 32'(i2c_ena), 32'd0);
        expect_results("t4", b_res, 1'b1);
        mode = 0;

        // enable low: sweep stops after the current register, no sweep_done
        b_res = res_cnt; b_sw = sweeps;
        pulse_trig();
        repeat (40) @(negedge clk);
        check("en0_nres", 32'(res_cnt - b_res), 32'd1);
        check("en0_nsweep", 32'(sweeps - b_sw), 32'd0);
        check("en0_idx", 32'(log_idx[b_res]), 32'd0);
        check("en0_data", 32'(log_data[b_res]), 32'h1000);
        check("en0_ena", 32'(i2c_ena), 32'd0);

        // 5: two extra triggers during a sweep -> one pending, one overrun
        b_res = res_cnt; b_sw = sweeps; b_ov = overruns;
        enable = 1'b1;
        pulse_trig();
        repeat (8) @(negedge clk);
        pulse_trig();
        repeat (8) @(negedge clk);
        pulse_trig();
        wait_sweeps("t5a", b_sw + 1, 120);
        repeat (3) @(negedge clk);
        check("t5_overrun", 32'(overruns - b_ov), 32'd1);
        check("t5_restart_lat", 32'(start_lat >= 1 && start_lat <= 2), 32'd1);
        wait_sweeps("t5b", b_sw + 2, 120);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_nres", 32'(res_cnt - b_res), 32'd8);
        check("t5_nsweep", 32'(sweeps - b_sw), 32'd2);
        check("t5_overrun_end", 32'(overruns - b_ov), 32'd1);
        expect_results("t5a", b_res, 1'b0);
        expect_results("t5b", b_res + 4, 1'b0);

        // 6: reset during the read phase of idx 1
        b_res = res_cnt;
        enable = 1'b1;
        pulse_trig();
        for (int i = 0; i < 60 && res_cnt < b_res + 1; i++) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 30 && !i2c_rw; i++) @(negedge clk);
        check("t6_rd_seen", 32'(i2c_ena && i2c_rw), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_ena", 32'(i2c_ena), 32'd0);
        check("t6_rw", 32'(i2c_rw), 32'd0);
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_res_data", 32'(res_data), 32'd0);
        rst = 1'b0; enable = 1'b0;
        b_res = res_cnt;
        repeat (10) @(negedge clk);
        check("t6_idle_ena", 32'(i2c_ena), 32'd0);
        check("t6_idle_nres", 32'(res_cnt - b_res), 32'd0);
        b_sw = sweeps;
        enable = 1'b1;
        pulse_trig();
        wait_sweeps("t6", b_sw + 1, 195);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_nres", 32'(res_cnt - b_res), 32'd4);
        expect_results("t6", b_res, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
